// File: rtl/ws2812_stream_output_if.sv
// ----------------------------------------------------------------------------
// ws2812_stream_output_if
// Pixel-fetch handshake between a pixel source and the WS2812 stream driver.
//   trigger       source -> driver  start a frame (honoured only when idle)
//   data_in       source -> driver  pixel word, WORD_BITS wide
//   data_valid    source -> driver  data_in holds a word this cycle
//   data_request  driver -> source  driver is fetching a word this cycle
// Modports: master = pixel source, slave = LED driver.
// ----------------------------------------------------------------------------
interface ws2812_stream_output_if #(
   parameter int WORD_BITS = 24
);
   logic                 trigger;
   logic [WORD_BITS-1:0] data_in;
   logic                 data_valid;
   logic                 data_request;

   modport master (
      output trigger,
      output data_in,
      output data_valid,
      input  data_request
   );

   modport slave (
      input  trigger,
      input  data_in,
      input  data_valid,
      output data_request
   );
endinterface

// File: rtl/ws2812_stream_output.sv
// ----------------------------------------------------------------------------
// ws2812_stream_output
// Serialises pixel words to a WS2812-family LED data pin using NRZ
// pulse-width timing, then closes each frame with a latch (reset) gap.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   px          pixel handshake (slave side of ws2812_stream_output_if)
//   out         serial LED data, inverted when INVERT = 1
//   busy        high whenever the driver is not idle
//   frame_done  one-cycle pulse in the last cycle of the latch gap
//   underrun    sticky flag: counted mode ran out of pixel data
// ----------------------------------------------------------------------------
module ws2812_stream_output #(
   parameter int unsigned INPUT_CLOCK = 12_000_000,
   parameter int          WORD_BITS   = 24,
   parameter int unsigned T0H_NS      = 350,
   parameter int unsigned T0L_NS      = 1050,
   parameter int unsigned T1H_NS      = 800,
   parameter int unsigned T1L_NS      = 600,
   parameter int unsigned RESET_NS    = 60000,
   parameter int          LED_COUNT   = 0,
   parameter bit          MSB_FIRST   = 1'b1,
   parameter bit          INVERT      = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst,
   ws2812_stream_output_if.slave         px,
   output logic                          out,
   output logic                          busy,
   output logic                          frame_done,
   output logic                          underrun
);

   // Cycle counts for each phase, truncated towards zero.
   function automatic int ticks(input longint unsigned ns);
      return int'((longint'(INPUT_CLOCK) * ns) / 64'd1_000_000_000);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T0H   = ticks(T0H_NS);
   localparam int T0L   = ticks(T0L_NS);
   localparam int T1H   = ticks(T1H_NS);
   localparam int T1L   = ticks(T1L_NS);
   localparam int TRES  = ticks(RESET_NS);
   localparam int CMAX  = max2(max2(max2(T0H, T1H), max2(T0L, T1L)), TRES);
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam int BIT_W = $clog2(WORD_BITS + 1);
   localparam int WC_W  = (LED_COUNT > 0) ? $clog2(LED_COUNT + 1) : 1;

   localparam logic [CNT_W-1:0] C_T0H  = CNT_W'(T0H - 1);
   localparam logic [CNT_W-1:0] C_T0L  = CNT_W'(T0L - 1);
   localparam logic [CNT_W-1:0] C_T1H  = CNT_W'(T1H - 1);
   localparam logic [CNT_W-1:0] C_T1L  = CNT_W'(T1L - 1);
   localparam logic [CNT_W-1:0] C_TRES = CNT_W'(TRES - 1);

   if (T0H < 2 || T0L < 2 || T1H < 2 || T1L < 2 || TRES < 2) begin : g_bad_timing
      $error("ws2812_stream_output: a phase is shorter than 2 clock cycles");
   end
   if (WORD_BITS < 1 || WORD_BITS > 64) begin : g_bad_width
      $error("ws2812_stream_output: WORD_BITS must be within 1..64");
   end
   if (INPUT_CLOCK < 12_000_000) begin : g_bad_clock
      $error("ws2812_stream_output: INPUT_CLOCK must be at least 12 MHz");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_HIGH,
      S_LOW,
      S_TAIL
   } state_t;

   state_t               r_state,     w_state_next;
   logic [CNT_W-1:0]     r_cnt,       w_cnt_next;
   logic [WORD_BITS-1:0] r_shift,     w_shift_next;
   logic [BIT_W-1:0]     r_bits_left, w_bits_left_next;
   logic [WC_W-1:0]      r_words,     w_words_next;
   logic                 r_underrun,  w_underrun_next;

   // The bit on the wire always sits at the "first" end of the shift
   // register; shifting towards that end exposes the following bit.
   logic [WORD_BITS-1:0] w_shifted;
   logic                 w_cur_bit;
   logic                 w_next_bit;
   logic                 w_in_bit;
   logic                 w_last_word;

   assign w_shifted   = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
   assign w_cur_bit   = MSB_FIRST ? r_shift[WORD_BITS-1]   : r_shift[0];
   assign w_next_bit  = MSB_FIRST ? w_shifted[WORD_BITS-1] : w_shifted[0];
   assign w_in_bit    = MSB_FIRST ? px.data_in[WORD_BITS-1] : px.data_in[0];
   assign w_last_word = (LED_COUNT > 0) && (r_words == WC_W'(LED_COUNT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_bits_left <= '0;
         r_words     <= '0;
         r_underrun  <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_shift     <= w_shift_next;
         r_bits_left <= w_bits_left_next;
         r_words     <= w_words_next;
         r_underrun  <= w_underrun_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_shift_next     = r_shift;
      w_bits_left_next = r_bits_left;
      w_words_next     = r_words;
      w_underrun_next  = r_underrun;

      case (r_state)
         S_IDLE: begin
            if (px.trigger) begin
               w_state_next    = S_FETCH;
               w_words_next    = '0;
               w_underrun_next = 1'b0;
            end
         end

         S_FETCH: begin
            if (px.data_valid) begin
               w_shift_next     = px.data_in;
               w_bits_left_next = BIT_W'(WORD_BITS - 1);
               w_words_next     = r_words + WC_W'(1);
               w_cnt_next       = w_in_bit ? C_T1H : C_T0H;
               w_state_next     = S_HIGH;
            end else begin
               // No stall allowed: a missing word ends the frame.
               w_cnt_next   = C_TRES;
               w_state_next = S_TAIL;
               if (LED_COUNT > 0) begin
                  w_underrun_next = 1'b1;
               end
            end
         end

         S_HIGH: begin
            if (r_cnt == '0) begin
               w_cnt_next   = w_cur_bit ? C_T1L : C_T0L;
               w_state_next = S_LOW;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         S_LOW: begin
            if (r_cnt != '0) begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end else if (r_bits_left != '0) begin
               w_shift_next     = w_shifted;
               w_bits_left_next = r_bits_left - BIT_W'(1);
               w_cnt_next       = w_next_bit ? C_T1H : C_T0H;
               w_state_next     = S_HIGH;
            end else if (w_last_word) begin
               // Counted frame complete: skip the fetch entirely.
               w_cnt_next   = C_TRES;
               w_state_next = S_TAIL;
            end else begin
               w_state_next = S_FETCH;
            end
         end

         S_TAIL: begin
            if (r_cnt == '0) begin
               w_state_next = S_IDLE;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign px.data_request = (r_state == S_FETCH);
   assign out             = (r_state == S_HIGH) ^ INVERT;
   assign busy            = (r_state != S_IDLE);
   assign frame_done      = (r_state == S_TAIL) && (r_cnt == '0);
   assign underrun        = r_underrun;

endmodule

// File: tb/tb_ws2812_stream_output.sv
// ----------------------------------------------------------------------------
// tb_ws2812_stream_output
// Four driver instances (stream default, counted 32-bit, counted underrun,
// LSB-first inverted) share one clock. Stimulus pushes the expected pin
// events into a per-instance queue; a per-instance monitor measures pulse
// and gap widths on the pin and pops/compares them as they occur.
// Event codes: kind*65536 + cycles, kind 1 = active pulse width,
// 2 = idle gap before the next pulse, 3 = idle run ending at frame_done.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ws2812_stream_output;

   localparam int T0H = 4, T0L = 12, T1H = 9, T1L = 7, TRES = 720;
   localparam int EV_H = 1, EV_L = 2, EV_D = 3;
   localparam int BUDGET = 5000;

   function automatic int cfg_wb(input int i);
      return (i == 1) ? 32 : 24;
   endfunction
   function automatic int cfg_lc(input int i);
      case (i)
         1:       return 2;
         2:       return 3;
         default: return 0;
      endcase
   endfunction
   function automatic bit cfg_msb(input int i);
      return (i == 3) ? 1'b0 : 1'b1;
   endfunction
   function automatic bit cfg_inv(input int i);
      return (i == 3) ? 1'b1 : 1'b0;
   endfunction

   logic        clk = 1'b0;
   logic [3:0]  rst_v;
   logic [3:0]  trig_v;
   logic [3:0]  pin_v, busy_v, done_v, und_v;

   logic [63:0] src_q [4][$];
   int          exp_q [4][$];
   int          req_cnt [4];
   int          rise_cnt [4];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic sb_check(input int i, input int kind, input int val);
      int e;
      checks++;
      if (exp_q[i].size() == 0) begin
         errors++;
         $display("FAIL sb%0d: unexpected event kind %0d width %0d, none required", i, kind, val);
      end else begin
         e = exp_q[i].pop_front();
         if (e != kind * 65536 + val) begin
            errors++;
            $display("FAIL sb%0d: got kind %0d width %0d, required kind %0d width %0d",
                     i, kind, val, e / 65536, e % 65536);
         end
      end
   endtask

   // end_kind: 0 = another word follows, 1 = failed fetch then latch gap,
   // 2 = counted frame ends straight into the latch gap.
   task automatic exp_word(input int i, input logic [63:0] w, input int end_kind, input int nbits);
      int wb;
      int idx;
      int hi;
      int lo;
      wb = cfg_wb(i);
      for (int k = 0; k < nbits; k++) begin
         idx = cfg_msb(i) ? (wb - 1 - k) : k;
         hi  = w[idx] ? T1H : T0H;
         lo  = w[idx] ? T1L : T0L;
         exp_q[i].push_back(EV_H * 65536 + hi);
         if (k < wb - 1)         exp_q[i].push_back(EV_L * 65536 + lo);
         else if (end_kind == 0) exp_q[i].push_back(EV_L * 65536 + lo + 1);
         else if (end_kind == 1) exp_q[i].push_back(EV_D * 65536 + lo + 1 + TRES);
         else                    exp_q[i].push_back(EV_D * 65536 + lo + TRES);
      end
   endtask

   task automatic pulse_trig(input int i);
      @(negedge clk);
      trig_v[i] = 1'b1;
      @(negedge clk);
      trig_v[i] = 1'b0;
   endtask

   // kind 0: rising pulses, 1: request cycles, 2: frame_done
   task automatic wait_evt(input int i, input int kind, input int target, input string name);
      int n;
      int val;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < BUDGET) begin
         @(negedge clk);
         n++;
         val = (kind == 0) ? rise_cnt[i] : (kind == 1) ? req_cnt[i] : int'(done_v[i]);
         hit = (val >= target);
      end
      chk({name, "_timeout"}, longint'(hit), 1);
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
      localparam int P_WB  = cfg_wb(gi);
      localparam int P_LC  = cfg_lc(gi);
      localparam bit P_MSB = cfg_msb(gi);
      localparam bit P_INV = cfg_inv(gi);

      ws2812_stream_output_if #(.WORD_BITS(P_WB)) bus ();
      logic w_out, w_busy, w_done, w_und;

      assign bus.trigger = trig_v[gi];

      ws2812_stream_output #(
         .WORD_BITS (P_WB),
         .LED_COUNT (P_LC),
         .MSB_FIRST (P_MSB),
         .INVERT    (P_INV)
      ) dut (
         .clk        (clk),
         .rst        (rst_v[gi]),
         .px         (bus.slave),
         .out        (w_out),
         .busy       (w_busy),
         .frame_done (w_done),
         .underrun   (w_und)
      );

      assign pin_v[gi]  = w_out;
      assign busy_v[gi] = w_busy;
      assign done_v[gi] = w_done;
      assign und_v[gi]  = w_und;

      // Pixel source: presents the head of src_q, pops it once accepted.
      initial begin
         logic [63:0] w;
         bit acc;
         acc = 1'b0;
         bus.data_valid = 1'b0;
         bus.data_in = '0;
         forever begin
            @(posedge clk);
            #1;
            if (acc && src_q[gi].size() > 0) void'(src_q[gi].pop_front());
            if (src_q[gi].size() > 0) begin
               w = src_q[gi][0];
               bus.data_in = w[P_WB-1:0];
               bus.data_valid = 1'b1;
            end else begin
               bus.data_valid = 1'b0;
            end
            @(negedge clk);
            acc = bus.data_request && bus.data_valid;
         end
      end

      // Pin monitor: measures active/idle run lengths per cycle.
      initial begin
         int hcnt;
         int lcnt;
         bit prev;
         bit have_fall;
         bit act;
         hcnt = 0;
         lcnt = 0;
         prev = 1'b0;
         have_fall = 1'b0;
         forever begin
            @(posedge clk);
            #1;
            if (rst_v[gi]) begin
               hcnt = 0;
               lcnt = 0;
               prev = 1'b0;
               have_fall = 1'b0;
            end else begin
               act = w_out ^ P_INV;
               if (bus.data_request) req_cnt[gi]++;
               if (act) begin
                  if (!prev) begin
                     rise_cnt[gi]++;
                     if (have_fall) sb_check(gi, EV_L, lcnt);
                  end
                  hcnt++;
               end else begin
                  if (prev) begin
                     sb_check(gi, EV_H, hcnt);
                     hcnt = 0;
                     lcnt = 0;
                     have_fall = 1'b1;
                  end
                  if (have_fall) lcnt++;
               end
               if (w_done) begin
                  sb_check(gi, EV_D, lcnt);
                  have_fall = 1'b0;
               end
               prev = act;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_v  = 4'hF;
      trig_v = 4'h0;
      for (int i = 0; i < 4; i++) begin
         req_cnt[i] = 0;
         rise_cnt[i] = 0;
      end
      repeat (3) @(negedge clk);
      rst_v = 4'h0;

      // Reset values
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst_out%0d", i), pin_v[i], cfg_inv(i));
         chk($sformatf("rst_busy%0d", i), busy_v[i], 0);
         chk($sformatf("rst_done%0d", i), done_v[i], 0);
         chk($sformatf("rst_underrun%0d", i), und_v[i], 0);
         chk($sformatf("rst_request%0d", i), req_cnt[i], 0);
      end

      // Stream mode, one word then no data.
      src_q[0].push_back(64'hA5F00F);
      exp_word(0, 64'hA5F00F, 1, 24);
      @(negedge clk);
      pulse_trig(0);
      chk("busy_after_trigger", busy_v[0], 1);
      wait_evt(0, 2, 1, "stream_done");
      chk("stream_events_left", exp_q[0].size(), 0);
      chk("stream_requests", req_cnt[0], 2);
      chk("stream_pulses", rise_cnt[0], 24);
      chk("stream_underrun", und_v[0], 0);
      @(negedge clk);
      chk("busy_after_done", busy_v[0], 0);

      // Triggers during HIGH and during TAIL are ignored.
      req_cnt[0] = 0;
      rise_cnt[0] = 0;
      src_q[0].push_back(64'h000003);
      exp_word(0, 64'h000003, 1, 24);
      pulse_trig(0);
      wait_evt(0, 0, 3, "ign_high_wait");
      pulse_trig(0);
      wait_evt(0, 1, 2, "ign_fetch_wait");
      repeat (3) @(negedge clk);
      pulse_trig(0);
      wait_evt(0, 2, 1, "ign_done");
      repeat (2) @(negedge clk);
      chk("ign_busy_stays_low", busy_v[0], 0);
      chk("ign_requests", req_cnt[0], 2);
      chk("ign_events_left", exp_q[0].size(), 0);

      // rst during the 10th bit's HIGH, with a coincident trigger.
      rise_cnt[0] = 0;
      src_q[0].push_back(64'hA5F00F);
      exp_word(0, 64'hA5F00F, 1, 9);
      pulse_trig(0);
      wait_evt(0, 0, 10, "rst_wait_bit10");
      chk("bit10_active", pin_v[0], 1);
      rst_v[0] = 1'b1;
      trig_v[0] = 1'b1;
      @(negedge clk);
      rst_v[0] = 1'b0;
      trig_v[0] = 1'b0;
      chk("rst_mid_out", pin_v[0], 0);
      chk("rst_mid_busy", busy_v[0], 0);
      @(negedge clk);
      chk("rst_trigger_ignored", busy_v[0], 0);
      chk("rst_mid_events_left", exp_q[0].size(), 0);
      repeat (5) @(negedge clk);
      chk("rst_no_frame_done", exp_q[0].size(), 0);
      src_q[0].push_back(64'h5A0FF0);
      exp_word(0, 64'h5A0FF0, 1, 24);
      pulse_trig(0);
      wait_evt(0, 2, 1, "restart_done");
      chk("restart_events_left", exp_q[0].size(), 0);

      // Counted mode, LED_COUNT=2, 32-bit words, data always valid.
      src_q[1].push_back(64'h8000_0001);
      src_q[1].push_back(64'hFFFF_0000);
      src_q[1].push_back(64'h1234_5678);
      exp_word(1, 64'h8000_0001, 0, 32);
      exp_word(1, 64'hFFFF_0000, 2, 32);
      pulse_trig(1);
      wait_evt(1, 2, 1, "counted_done");
      chk("counted_requests", req_cnt[1], 2);
      chk("counted_pulses", rise_cnt[1], 64);
      chk("counted_underrun", und_v[1], 0);
      chk("counted_words_left", src_q[1].size(), 1);
      chk("counted_events_left", exp_q[1].size(), 0);
      src_q[1].delete();

      // Counted mode, LED_COUNT=3, only one word available.
      src_q[2].push_back(64'h00FF00);
      exp_word(2, 64'h00FF00, 1, 24);
      pulse_trig(2);
      wait_evt(2, 0, 1, "underrun_first_pulse");
      chk("underrun_low_mid", und_v[2], 0);
      wait_evt(2, 1, 2, "underrun_fetch2");
      chk("underrun_in_fetch", und_v[2], 0);
      @(negedge clk);
      chk("underrun_after_fetch", und_v[2], 1);
      wait_evt(2, 2, 1, "underrun_done");
      chk("underrun_sticky", und_v[2], 1);
      chk("underrun_events_left", exp_q[2].size(), 0);
      src_q[2].push_back(64'h000080);
      exp_word(2, 64'h000080, 1, 24);
      pulse_trig(2);
      chk("underrun_cleared", und_v[2], 0);
      wait_evt(2, 2, 1, "underrun_done2");
      chk("underrun_again", und_v[2], 1);

      // LSB first, inverted pin.
      src_q[3].push_back(64'h000001);
      exp_word(3, 64'h000001, 1, 24);
      pulse_trig(3);
      wait_evt(3, 0, 1, "inv_first_pulse");
      chk("inv_active_level", pin_v[3], 0);
      wait_evt(3, 2, 1, "inv_done");
      @(negedge clk);
      chk("inv_idle_level", pin_v[3], 1);
      chk("inv_pulses", rise_cnt[3], 24);
      chk("inv_events_left", exp_q[3].size(), 0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
